// File: rtl/store_buffer_pkg.sv
// Shared constants and entry type for the store buffer and its forwarding matcher.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: finds the youngest valid entry whose address matches the load.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  head,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid[gi] && (entries[gi].addr == addr);
        end
    endgenerate

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (match[idx]) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between core and data memory; drains one store per non-load cycle.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CpuStore,
    input  logic              CpuLoad,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuData,
    output logic [DATA_W-1:0] LoadData,
    output logic              Stall,
    output logic              Empty,
    output logic              MemWriteEn,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full;
    logic               accept;
    logic               drain;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    sb_entry_t          head_entry;

    assign full   = (count_q == CNT_W'(DEPTH));
    // Reset gates both paths so memory init is never overwritten.
    assign accept = !Reset && CpuStore && !CpuLoad && !full;
    assign drain  = !Reset && !CpuLoad && (count_q != '0);

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (accept) begin
            entries_d[tail_q] = '{addr: CpuAddr, data: CpuData};
            valid_d[tail_q]   = 1'b1;
            tail_d            = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(drain);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; the valid mask decides what is live.
    always_ff @(posedge Clk) begin
        entries_q <= entries_d;
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (entries_q),
        .valid   (valid_q),
        .head    (head_q),
        .addr    (CpuAddr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_comb begin
        head_entry = entries_q[head_q];
        MemWriteEn = drain;
        MemAddress = '0;
        MemDataIn  = '0;
        if (CpuLoad) begin
            MemAddress = CpuAddr;
        end else if (drain) begin
            MemAddress = head_entry.addr;
            MemDataIn  = head_entry.data;
        end
    end

    assign Stall    = !Reset && CpuStore && (full || CpuLoad);
    assign Empty    = (count_q == '0);
    assign LoadData = fwd_hit ? fwd_data : MemDataOut;

endmodule
